// File: rtl/tester_ctrl_pkg.sv
// Shared types and command constants for the tester control FSM.
package tester_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARG     = 3'd1,
        S_RD      = 3'd2,
        S_WRITE_C = 3'd3,
        S_WRITE_S = 3'd4,
        S_RESET   = 3'd5,
        S_WAIT    = 3'd6,
        S_SEND    = 3'd7
    } state_e;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_SEND  = 2'b01;
    localparam logic [1:0] OP_SETUP = 2'b10;
    localparam logic [1:0] OP_RESET = 2'b11;

    localparam logic [5:0] CH_ALL  = 6'h3F;
    localparam logic [1:0] UTX_TAG = 2'b01;

endpackage

// File: rtl/tester_ctrl_timer.sv
// Loadable down-counter with zero flag; shared by the reset pulse and the watchdog.
module tester_ctrl_timer #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero_c
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/tester_ctrl_fsm.sv
// Tester control FSM: decodes UART commands/switches, sequences memory RMW and UART echo.
// Define TESTER_WDT_EN to enable the watchdog in ARG/WRITE_*/WAIT/SEND.
module tester_ctrl_fsm
    import tester_ctrl_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned DATA_W     = 6,
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                                in_clk,
    input  logic                                in_rst,
    input  logic [N_CH-1:0]                     in_push_sw,
    input  logic                                in_push_rst,
    input  logic [7:0]                          in_urx,
    input  logic                                in_urx_vld,
    input  logic [DATA_W-1:0]                   in_mem,
    input  logic                                in_mem_w_rd,
    input  logic                                in_utx_s_bs,
    input  logic                                in_utx_s_rd,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] out_mem_addr,
    output logic [DATA_W-1:0]                   out_mem,
    output logic                                out_mem_w_en,
    output logic [7:0]                          out_utx_data,
    output logic                                out_utx_s_en,
    output logic                                out_rst,
    output logic                                out_err
);

    localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned TMR_MAX = (RST_CYCLES > TIMEOUT) ? RST_CYCLES : TIMEOUT;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    state_e              r_state, w_state_nxt;
    logic [CH_W-1:0]     r_addr, w_addr_nxt;
    logic [DATA_W-1:0]   r_mem, w_mem_nxt;
    logic                r_w_en, w_w_en_nxt;
    logic [7:0]          r_utx, w_utx_nxt;
    logic                r_s_en, w_s_en_nxt;
    logic                r_rst, w_rst_nxt;
    logic                r_err, w_err_nxt;
    logic                r_rmw, w_rmw_nxt;
    logic                r_all, w_all_nxt;

    logic [CH_W-1:0]     w_sw_ch;
    logic [5:0]          w_cmd_ch;
    logic                w_ch_ok;
    logic                w_tmr_load;
    logic [TMR_W-1:0]    w_tmr_val;
    logic                w_tmr_zero;

    assign w_cmd_ch = in_urx[5:0];
    assign w_ch_ok  = (32'(w_cmd_ch) < N_CH);

    // Lowest-numbered pressed switch wins.
    always_comb begin
        w_sw_ch = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--)
            if (in_push_sw[i]) w_sw_ch = CH_W'(i);
    end

`ifdef TESTER_WDT_EN
    assign w_tmr_load = (w_state_nxt != r_state);
`else
    assign w_tmr_load = (w_state_nxt != r_state) && (w_state_nxt == S_RESET);
`endif
    assign w_tmr_val = (w_state_nxt == S_RESET) ? TMR_W'(RST_CYCLES - 1) : TMR_W'(TIMEOUT - 1);

    tester_ctrl_timer #(.W(TMR_W)) u_timer (
        .i_clk      (in_clk),
        .i_rst_n    (in_rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero_c   (w_tmr_zero)
    );

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_mem   <= '0;
            r_w_en  <= 1'b0;
            r_utx   <= '0;
            r_s_en  <= 1'b0;
            r_rst   <= 1'b1;
            r_err   <= 1'b0;
            r_rmw   <= 1'b0;
            r_all   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_mem   <= w_mem_nxt;
            r_w_en  <= w_w_en_nxt;
            r_utx   <= w_utx_nxt;
            r_s_en  <= w_s_en_nxt;
            r_rst   <= w_rst_nxt;
            r_err   <= w_err_nxt;
            r_rmw   <= w_rmw_nxt;
            r_all   <= w_all_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_mem_nxt   = r_mem;
        w_w_en_nxt  = r_w_en;
        w_utx_nxt   = r_utx;
        w_s_en_nxt  = r_s_en;
        w_rst_nxt   = r_rst;
        w_err_nxt   = 1'b0;
        w_rmw_nxt   = r_rmw;
        w_all_nxt   = r_all;

        case (r_state)
            S_IDLE: begin
                if (|in_push_sw) begin
                    w_addr_nxt  = w_sw_ch;
                    w_rmw_nxt   = 1'b1;
                    w_state_nxt = S_RD;
                end else if (in_urx_vld) begin
                    case (in_urx[7:6])
                        OP_SEND: begin
                            if (w_cmd_ch == CH_ALL) begin
                                w_all_nxt   = 1'b1;
                                w_addr_nxt  = '0;
                                w_rmw_nxt   = 1'b0;
                                w_state_nxt = S_RD;
                            end else if (w_ch_ok) begin
                                w_addr_nxt  = CH_W'(w_cmd_ch);
                                w_rmw_nxt   = 1'b0;
                                w_state_nxt = S_RD;
                            end else begin
                                w_err_nxt = 1'b1;
                            end
                        end
                        OP_SETUP: begin
                            if (w_ch_ok) begin
                                w_addr_nxt  = CH_W'(w_cmd_ch);
                                w_state_nxt = S_ARG;
                            end else begin
                                w_err_nxt = 1'b1;
                            end
                        end
                        OP_RESET: begin
                            w_rst_nxt   = 1'b0;
                            w_state_nxt = S_RESET;
                        end
                        default: ;
                    endcase
                end else if (in_push_rst) begin
                    w_rst_nxt   = 1'b0;
                    w_state_nxt = S_RESET;
                end
            end
            S_ARG: begin
                if (in_urx_vld) begin
                    w_mem_nxt   = in_urx[DATA_W-1:0];
                    w_w_en_nxt  = 1'b1;
                    w_state_nxt = S_WRITE_C;
                end
            end
            // Switch path toggles the flag bit; otherwise latch the echo byte.
            S_RD: begin
                if (r_rmw) begin
                    w_mem_nxt             = in_mem;
                    w_mem_nxt[DATA_W-1]   = ~in_mem[DATA_W-1];
                    w_w_en_nxt            = 1'b1;
                    w_rmw_nxt             = 1'b0;
                    w_state_nxt           = S_WRITE_S;
                end else begin
                    w_utx_nxt   = {UTX_TAG, 6'(in_mem)};
                    w_state_nxt = S_WAIT;
                end
            end
            S_WRITE_C, S_WRITE_S: begin
                if (in_mem_w_rd) begin
                    w_w_en_nxt  = 1'b0;
                    w_state_nxt = S_RD;
                end
            end
            S_WAIT: begin
                if (!in_utx_s_bs) begin
                    w_s_en_nxt  = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (in_utx_s_rd) begin
                    w_s_en_nxt = 1'b0;
                    if (r_all && (r_addr != CH_W'(N_CH - 1))) begin
                        w_addr_nxt  = r_addr + 1'b1;
                        w_state_nxt = S_RD;
                    end else begin
                        w_all_nxt   = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_RESET: begin
                if (w_tmr_zero) begin
                    w_rst_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

`ifdef TESTER_WDT_EN
        // A legitimate exit in the expiry cycle takes precedence over the timeout.
        if ((r_state == S_ARG || r_state == S_WRITE_C || r_state == S_WRITE_S ||
             r_state == S_WAIT || r_state == S_SEND) &&
            w_tmr_zero && (w_state_nxt == r_state)) begin
            w_err_nxt   = 1'b1;
            w_w_en_nxt  = 1'b0;
            w_s_en_nxt  = 1'b0;
            w_all_nxt   = 1'b0;
            w_rmw_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
        end
`endif
    end

    assign out_mem_addr = r_addr;
    assign out_mem      = r_mem;
    assign out_mem_w_en = r_w_en;
    assign out_utx_data = r_utx;
    assign out_utx_s_en = r_s_en;
    assign out_rst      = r_rst;
    assign out_err      = r_err;

endmodule

// File: tb/tb_tester_ctrl_fsm.sv
// Directed self-checking bench for tester_ctrl_fsm (default build, N_CH=4, DATA_W=6).
module tb_tester_ctrl_fsm;

    logic       clk;
    logic       in_rst;
    logic [3:0] in_push_sw;
    logic       in_push_rst;
    logic [7:0] in_urx;
    logic       in_urx_vld;
    logic [5:0] in_mem;
    logic       in_mem_w_rd;
    logic       in_utx_s_bs;
    logic       in_utx_s_rd;
    logic [1:0] out_mem_addr;
    logic [5:0] out_mem;
    logic       out_mem_w_en;
    logic [7:0] out_utx_data;
    logic       out_utx_s_en;
    logic       out_rst;
    logic       out_err;

    logic [5:0] mem [4];
    int         n_checks;
    int         n_fail;

    assign in_mem = mem[out_mem_addr];

    tester_ctrl_fsm #(
        .N_CH(4), .DATA_W(6), .RST_CYCLES(16), .TIMEOUT(1024)
    ) dut (
        .in_clk       (clk),
        .in_rst       (in_rst),
        .in_push_sw   (in_push_sw),
        .in_push_rst  (in_push_rst),
        .in_urx       (in_urx),
        .in_urx_vld   (in_urx_vld),
        .in_mem       (in_mem),
        .in_mem_w_rd  (in_mem_w_rd),
        .in_utx_s_bs  (in_utx_s_bs),
        .in_utx_s_rd  (in_utx_s_rd),
        .out_mem_addr (out_mem_addr),
        .out_mem      (out_mem),
        .out_mem_w_en (out_mem_w_en),
        .out_utx_data (out_utx_data),
        .out_utx_s_en (out_utx_s_en),
        .out_rst      (out_rst),
        .out_err      (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_urx     = b;
        in_urx_vld = 1'b1;
        @(negedge clk);
        in_urx_vld = 1'b0;
    endtask

    // Wait for a write request, check it, hold it, then complete it.
    task automatic serve_write(input string tag, input logic [1:0] ea, input logic [5:0] ed);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (out_mem_w_en) got = 1;
            else @(negedge clk);
        end
        chk({tag, "_wen"}, 32'(got), 32'd1);
        chk({tag, "_addr"}, 32'(out_mem_addr), 32'(ea));
        chk({tag, "_data"}, 32'(out_mem), 32'(ed));
        repeat (2) @(negedge clk);
        chk({tag, "_wen_hold"}, 32'(out_mem_w_en), 32'd1);
        mem[out_mem_addr] = out_mem;
        in_mem_w_rd = 1'b1;
        @(negedge clk);
        in_mem_w_rd = 1'b0;
        chk({tag, "_wen_drop"}, 32'(out_mem_w_en), 32'd0);
    endtask

    // Wait for a send request, check the byte, hold it, then complete it.
    task automatic serve_send(input string tag, input logic [7:0] ed);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (out_utx_s_en) got = 1;
            else @(negedge clk);
        end
        chk({tag, "_sen"}, 32'(got), 32'd1);
        chk({tag, "_data"}, 32'(out_utx_data), 32'(ed));
        repeat (3) @(negedge clk);
        chk({tag, "_sen_hold"}, 32'(out_utx_s_en), 32'd1);
        chk({tag, "_data_hold"}, 32'(out_utx_data), 32'(ed));
        in_utx_s_rd = 1'b1;
        @(negedge clk);
        in_utx_s_rd = 1'b0;
        chk({tag, "_sen_drop"}, 32'(out_utx_s_en), 32'd0);
    endtask

    // Counts consecutive negedges with out_rst low, bounded.
    task automatic measure_rst(input string tag);
        int low = 0;
        for (int i = 0; i < 40 && !out_rst; i++) begin
            low++;
            @(negedge clk);
        end
        chk({tag, "_low_clks"}, 32'(low), 32'd16);
    endtask

    initial begin
        bit seen;
        n_checks    = 0;
        n_fail      = 0;
        in_rst      = 1'b0;
        in_push_sw  = '0;
        in_push_rst = 1'b0;
        in_urx      = '0;
        in_urx_vld  = 1'b0;
        in_mem_w_rd = 1'b0;
        in_utx_s_bs = 1'b0;
        in_utx_s_rd = 1'b0;
        mem[0] = 6'h01; mem[1] = 6'h05; mem[2] = 6'h15; mem[3] = 6'h0C;
        repeat (3) @(negedge clk);
        chk("rst_out_rst", 32'(out_rst), 32'd1);
        chk("rst_outs", {out_mem_w_en, out_utx_s_en, out_err, out_mem_addr, out_mem, out_utx_data},
            32'd0);
        in_rst = 1'b1;
        @(negedge clk);

        // SEND ch2: 8'h42, mem[2]=15 -> 55
        send_byte(8'h42);
        chk("send2_addr", 32'(out_mem_addr), 32'd2);
        serve_send("send2", 8'h55);

        // SETUP ch1 then data 2A, echo 6A
        send_byte(8'h81);
        send_byte(8'h2A);
        serve_write("setup1", 2'd1, 6'h2A);
        serve_send("setup1_echo", 8'h6A);

        // Switches 0110: ch1 wins, 05 -> 25
        mem[1] = 6'h05;
        in_push_sw = 4'b0110;
        @(negedge clk);
        in_push_sw = '0;
        serve_write("sw1", 2'd1, 6'h25);
        serve_send("sw1_echo", 8'h65);
        chk("sw_ch2_kept", 32'(mem[2]), 32'h15);

        // Switch beats simultaneous UART command; command is not acted on
        in_push_sw = 4'b1000;
        in_urx     = 8'h42;
        in_urx_vld = 1'b1;
        @(negedge clk);
        in_push_sw = '0;
        in_urx_vld = 1'b0;
        serve_write("prio_sw3", 2'd3, 6'h2C);
        serve_send("prio_echo", 8'h6C);
        repeat (4) @(negedge clk);
        chk("prio_no_extra_send", 32'(out_utx_s_en), 32'd0);

        // SEND all: ch0..ch3 in order
        mem[0] = 6'h01; mem[1] = 6'h02; mem[2] = 6'h03; mem[3] = 6'h04;
        send_byte(8'h7F);
        serve_send("all0", 8'h41);
        serve_send("all1", 8'h42);
        serve_send("all2", 8'h43);
        serve_send("all3", 8'h44);
        repeat (5) @(negedge clk);
        chk("all_done_idle", 32'(out_utx_s_en), 32'd0);

        // Bad channel 45: one-cycle error, no requests
        send_byte(8'h45);
        chk("badch_err", 32'(out_err), 32'd1);
        @(negedge clk);
        chk("badch_err_pulse", 32'(out_err), 32'd0);
        seen = 0;
        repeat (5) begin
            if (out_mem_w_en || out_utx_s_en) seen = 1;
            @(negedge clk);
        end
        chk("badch_no_req", 32'(seen), 32'd0);

        // SETUP to all-channels is illegal
        send_byte(8'hBF);
        chk("setup_all_err", 32'(out_err), 32'd1);
        @(negedge clk);

        // NOP ignored
        send_byte(8'h05);
        chk("nop_no_err", 32'(out_err), 32'd0);
        @(negedge clk);

        // RESET command and button: 16 clocks low
        send_byte(8'hC0);
        measure_rst("rst_cmd");
        @(negedge clk);
        in_push_rst = 1'b1;
        @(negedge clk);
        in_push_rst = 1'b0;
        measure_rst("rst_btn");
        chk("rst_back_high", 32'(out_rst), 32'd1);

        // Busy holds off the send
        in_utx_s_bs = 1'b1;
        send_byte(8'h40);
        repeat (10) @(negedge clk);
        chk("busy_hold_sen", 32'(out_utx_s_en), 32'd0);
        in_utx_s_bs = 1'b0;
        serve_send("busy_send0", 8'h41);

        // Async reset during WRITE_C drops the write request
        send_byte(8'h80);
        send_byte(8'h11);
        @(negedge clk);
        chk("wrc_wen_up", 32'(out_mem_w_en), 32'd1);
        #2 in_rst = 1'b0;
        #1;
        chk("wrc_rst_wen", 32'(out_mem_w_en), 32'd0);
        chk("wrc_rst_out_rst", 32'(out_rst), 32'd1);
        @(negedge clk);
        in_rst = 1'b1;
        @(negedge clk);
        send_byte(8'h40);
        serve_send("after_rst_send0", 8'h41);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
